// File: rtl/pipe_stage_reg.sv
// Pipeline register between two stages with valid/ready handshake, stall, flush and an optional 2-entry skid buffer.
// Latency 1; in_ready falls when the skid entry is occupied (SKID=1) or when a held entry is not being drained (SKID=0).
module pipe_stage_reg #(
    parameter int DATA_W = 40,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] fwd_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic              e0_vld_q, e0_vld_d;
    logic              e1_vld_q, e1_vld_d;
    logic [DATA_W-1:0] e0_dat_q, e0_dat_d;
    logic [DATA_W-1:0] e1_dat_q, e1_dat_d;
    logic [1:0]        occ_q, occ_d;
    logic [CNT_W-1:0]  bub_q, bub_d;
    logic [CNT_W-1:0]  flc_q, flc_d;
    logic              in_fire, out_fire, room;

    // With the skid entry, readiness depends only on a flop so no combinational path from out_ready.
    assign room      = (SKID != 0) ? ~e1_vld_q : (~e0_vld_q | out_ready);
    assign in_ready  = rst_n & ~stall & ~flush & room;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = e0_vld_q & out_ready & ~stall;

    assign out_valid  = e0_vld_q;
    assign out_data   = e0_dat_q;
    assign fwd_data   = e0_vld_q ? e0_dat_q : '0;
    assign occupancy  = occ_q;
    assign bubble_cnt = bub_q;
    assign flush_cnt  = flc_q;

    always_comb begin
        e0_vld_d = e0_vld_q;
        e0_dat_d = e0_dat_q;
        e1_vld_d = e1_vld_q;
        e1_dat_d = e1_dat_q;
        if (flush) begin
            e0_vld_d = 1'b0;
            e0_dat_d = '0;
            e1_vld_d = 1'b0;
            e1_dat_d = '0;
        end else if (!stall) begin
            case ({in_fire, out_fire})
                2'b10: begin
                    if (!e0_vld_q) begin
                        e0_vld_d = 1'b1;
                        e0_dat_d = in_data;
                    end else begin
                        e1_vld_d = 1'b1;
                        e1_dat_d = in_data;
                    end
                end
                2'b01: begin
                    e0_vld_d = e1_vld_q;
                    e0_dat_d = e1_vld_q ? e1_dat_q : '0;
                    e1_vld_d = 1'b0;
                    e1_dat_d = '0;
                end
                2'b11: begin
                    if (e1_vld_q) begin
                        e0_dat_d = e1_dat_q;
                        e1_dat_d = in_data;
                    end else begin
                        e0_dat_d = in_data;
                    end
                end
                default: ;
            endcase
        end
        // Without a skid entry the second slot is never populated.
        if (SKID == 0) begin
            e1_vld_d = 1'b0;
            e1_dat_d = '0;
        end
    end

    always_comb begin
        occ_d = {1'b0, e0_vld_d} + {1'b0, e1_vld_d};
        bub_d = bub_q;
        flc_d = flc_q;
        if (!stall && !flush && !e0_vld_q && bub_q != CNT_MAX)
            bub_d = bub_q + CNT_ONE;
        if (flush && flc_q != CNT_MAX)
            flc_d = flc_q + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e0_vld_q <= 1'b0;
            e1_vld_q <= 1'b0;
            e0_dat_q <= '0;
            e1_dat_q <= '0;
            occ_q    <= 2'd0;
            bub_q    <= '0;
            flc_q    <= '0;
        end else begin
            e0_vld_q <= e0_vld_d;
            e1_vld_q <= e1_vld_d;
            e0_dat_q <= e0_dat_d;
            e1_dat_q <= e1_dat_d;
            occ_q    <= occ_d;
            bub_q    <= bub_d;
            flc_q    <= flc_d;
        end
    end

endmodule
